// File: rtl/op_responder.sv
// Execution responder for the start/busy/done benchmark protocol: computes a
// 32-bit result on accept and releases it after an engine-dependent latency.

module op_responder_checker (
    input logic        clk,
    input logic        rst,
    input logic        busy,
    input logic        done,
    input logic [15:0] ops_served
);

    // A completion cycle always presents an idle responder.
    a_done_not_busy: assert property (@(posedge clk) disable iff (rst)
        done |-> !busy);

    // The completion pulse is a single cycle wide.
    a_done_one_cycle: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

    // Each completion advances the served counter by exactly one.
    a_served_step: assert property (@(posedge clk) disable iff (rst)
        done |-> (ops_served == ($past(ops_served) + 16'd1)));

endmodule

module op_responder #(
    parameter int B2_LAT_BIN  = 1,
    parameter int B2_LAT_DEC  = 8,
    parameter int B2_LAT_DUO  = 6,
    parameter int B10_LAT_DEC = 1,
    parameter int B10_LAT_BIN = 6,
    parameter int B10_LAT_DUO = 6,
    parameter int B12_LAT_DUO = 1,
    parameter int B12_LAT_BIN = 6,
    parameter int B12_LAT_DEC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cond_sel,
    input  logic [3:0]  opcode,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [15:0] ops_served
);

    localparam logic [3:0] OP_BIN_ADD   = 4'd0;
    localparam logic [3:0] OP_BIN_SUB   = 4'd1;
    localparam logic [3:0] OP_BIN_MUL   = 4'd2;
    localparam logic [3:0] OP_DEC_ADD   = 4'd3;
    localparam logic [3:0] OP_DEC_SUB   = 4'd4;
    localparam logic [3:0] OP_DEC_MUL10 = 4'd5;
    localparam logic [3:0] OP_DUO_ADD12 = 4'd6;
    localparam logic [3:0] OP_DUO_SUB12 = 4'd7;
    localparam logic [3:0] OP_DUO_MUL3  = 4'd8;

    typedef enum logic [1:0] {FAM_BIN, FAM_DEC, FAM_DUO, FAM_NONE} family_t;
    typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;

    // Latencies are held in 8 bits; zero means one cycle, oversize saturates.
    function automatic logic [7:0] clamp_lat(input int lat);
        logic [7:0] v;
        if (lat < 32'sd1) begin
            v = 8'd1;
        end else if (lat > 32'sd255) begin
            v = 8'd255;
        end else begin
            v = lat[7:0];
        end
        return v;
    endfunction

    localparam logic [7:0] LAT_B2_BIN  = clamp_lat(B2_LAT_BIN);
    localparam logic [7:0] LAT_B2_DEC  = clamp_lat(B2_LAT_DEC);
    localparam logic [7:0] LAT_B2_DUO  = clamp_lat(B2_LAT_DUO);
    localparam logic [7:0] LAT_B10_BIN = clamp_lat(B10_LAT_BIN);
    localparam logic [7:0] LAT_B10_DEC = clamp_lat(B10_LAT_DEC);
    localparam logic [7:0] LAT_B10_DUO = clamp_lat(B10_LAT_DUO);
    localparam logic [7:0] LAT_B12_BIN = clamp_lat(B12_LAT_BIN);
    localparam logic [7:0] LAT_B12_DEC = clamp_lat(B12_LAT_DEC);
    localparam logic [7:0] LAT_B12_DUO = clamp_lat(B12_LAT_DUO);

    function automatic family_t op_family(input logic [3:0] op);
        family_t f;
        case (op)
            OP_BIN_ADD, OP_BIN_SUB, OP_BIN_MUL:       f = FAM_BIN;
            OP_DEC_ADD, OP_DEC_SUB, OP_DEC_MUL10:     f = FAM_DEC;
            OP_DUO_ADD12, OP_DUO_SUB12, OP_DUO_MUL3:  f = FAM_DUO;
            default:                                  f = FAM_NONE;
        endcase
        return f;
    endfunction

    function automatic logic [7:0] pick_col(input family_t fam, input logic [7:0] l_bin,
                                            input logic [7:0] l_dec, input logic [7:0] l_duo);
        logic [7:0] l;
        case (fam)
            FAM_BIN: l = l_bin;
            FAM_DEC: l = l_dec;
            FAM_DUO: l = l_duo;
            default: l = 8'd1;
        endcase
        return l;
    endfunction

    // Forced conditions pick an engine row; routed mode uses each family's native engine.
    function automatic logic [7:0] select_latency(input logic [1:0] cond, input family_t fam);
        logic [7:0] l;
        case (cond)
            2'd0:    l = pick_col(fam, LAT_B2_BIN, LAT_B2_DEC, LAT_B2_DUO);
            2'd1:    l = pick_col(fam, LAT_B10_BIN, LAT_B10_DEC, LAT_B10_DUO);
            2'd2:    l = pick_col(fam, LAT_B12_BIN, LAT_B12_DEC, LAT_B12_DUO);
            default: l = pick_col(fam, LAT_B2_BIN, LAT_B10_DEC, LAT_B12_DUO);
        endcase
        return l;
    endfunction

    function automatic logic [31:0] compute_result(input logic [3:0] op, input logic [15:0] a,
                                                   input logic [15:0] b);
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r;
        a32 = {16'h0000, a};
        b32 = {16'h0000, b};
        case (op)
            OP_BIN_ADD, OP_DEC_ADD, OP_DUO_ADD12: r = a32 + b32;
            OP_BIN_SUB, OP_DEC_SUB, OP_DUO_SUB12: r = a32 - b32;
            OP_BIN_MUL:                           r = a32 * b32;
            OP_DEC_MUL10:                         r = a32 * 32'd10;
            OP_DUO_MUL3:                          r = a32 * 32'd3;
            default:                              r = 32'd0;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_next_s;
    logic [31:0] pending_r;
    logic [31:0] pending_next_s;
    logic        busy_r;
    logic        busy_next_s;
    logic        done_r;
    logic        done_next_s;
    logic [31:0] result_r;
    logic [31:0] result_next_s;
    logic [15:0] served_r;
    logic [15:0] served_next_s;
    logic [31:0] calc_result_s;
    logic [7:0]  calc_lat_s;

    // Operand-side datapath evaluated every cycle; only captured on accept.
    always_comb begin
        calc_result_s = compute_result(opcode, op_a, op_b);
        calc_lat_s    = select_latency(cond_sel, op_family(opcode));
    end

    // Next-state and next-output logic for the accept/run handshake.
    always_comb begin
        next_state_s   = state_r;
        cnt_next_s     = cnt_r;
        pending_next_s = pending_r;
        busy_next_s    = busy_r;
        done_next_s    = 1'b0;
        result_next_s  = result_r;
        served_next_s  = served_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    pending_next_s = calc_result_s;
                    cnt_next_s     = calc_lat_s - 8'd1;
                    busy_next_s    = 1'b1;
                    next_state_s   = ST_RUN;
                end else begin
                    busy_next_s    = 1'b0;
                end
            end
            ST_RUN: begin
                if (cnt_r != 8'd0) begin
                    cnt_next_s     = cnt_r - 8'd1;
                end else begin
                    result_next_s  = pending_r;
                    done_next_s    = 1'b1;
                    busy_next_s    = 1'b0;
                    served_next_s  = served_r + 16'd1;
                    next_state_s   = ST_IDLE;
                end
            end
            default: begin
                busy_next_s  = 1'b0;
                cnt_next_s   = 8'd0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight op without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            pending_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= 32'd0;
            served_r  <= 16'd0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            pending_r <= pending_next_s;
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            result_r  <= result_next_s;
            served_r  <= served_next_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;
    assign ops_served = served_r;

    op_responder_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy_r),
        .done       (done_r),
        .ops_served (served_r)
    );

endmodule

// File: doc/op_responder.md
# op_responder

Execution responder for the benchmark start/busy/done protocol. It accepts one operation request per handshake: condition select, opcode, and two 16-bit operands. It computes the 32-bit result and holds it internally for a parameterised number of cycles that models the selected number-base engine, then pulses `done`. It sits on the target side of the benchmark controller and lets cycle counts be compared across forced-base conditions and suitability routing.

## Interface
- `B2_LAT_BIN`, 1, base-2 engine latency for binary-family ops
- `B2_LAT_DEC`, 8, base-2 engine latency for decimal-family ops
- `B2_LAT_DUO`, 6, base-2 engine latency for duodecimal-family ops
- `B10_LAT_DEC`, 1 / `B10_LAT_BIN`, 6 / `B10_LAT_DUO`, 6, base-10 engine latencies
- `B12_LAT_DUO`, 1 / `B12_LAT_BIN`, 6 / `B12_LAT_DEC`, 8, base-12 engine latencies
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request strobe; accepted only when `busy`=0
- `cond_sel`  in  2  0=base-2, 1=base-10, 2=base-12 forced; 3=route by opcode suitability
- `opcode`  in  4  `OP_*` code from common_opcodes.vh
- `op_a`, `op_b`  in  16  operands, unsigned
- `busy`  out  1  request in flight
- `done`  out  1  one-cycle completion pulse
- `result`  out  32  result of last completed op
- `ops_served`  out  16  count of completed ops, wraps at 65535→0

## Operation
- Opcode families:
  - binary: `OP_BIN_ADD`, `OP_BIN_SUB`, `OP_BIN_MUL`
  - decimal: `OP_DEC_ADD`, `OP_DEC_SUB`, `OP_DEC_MUL10`
  - duodecimal: `OP_DUO_ADD12`, `OP_DUO_SUB12`, `OP_DUO_MUL3`
- Arithmetic: operands are zero-extended to 32 bits.
  - ADD: a+b.
  - SUB: a−b mod 2^32; negative results wrap to two's complement.
  - BIN_MUL: a*b.
  - DEC_MUL10: a*10.
  - DUO_MUL3: a*3.
  - `op_b` is ignored for the MUL10 and MUL3 ops.
  - Unknown opcode: result 0, latency 1.
- Latency selection L:
  - `cond_sel` 0/1/2 picks that engine's row; the family picks the column.
  - `cond_sel`=3: binary uses `B2_LAT_BIN`, decimal uses `B10_LAT_DEC`, duodecimal uses `B12_LAT_DUO`.
  - A parameter value of 0 is treated as 1.
- FSM states:
  - IDLE: `busy`=0. On `start`=1:
    - latch the computed result into a pending register;
    - load the counter with L−1;
    - `busy`←1;
    - go to RUN.
  - RUN: `busy`=1.
    - If counter≠0: decrement.
    - Else: `result`←pending, `done`←1 for one cycle, `busy`←0, `ops_served`+1, go to IDLE.
- Inputs are sampled only at the accept edge. Changes to `opcode`/operands/`cond_sel` during RUN have no effect.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `ops_served`=0, state IDLE, counter 0.
- Accept edge E0 is the clock edge where `start`=1 and `busy`=0.
- `busy` is high from E0 to E_L. `done`=1 and the new `result` are visible from edge E0+L for exactly one cycle.
- `result` holds until the next completion. It is unchanged during a following op's RUN.
- Back-to-back: `start` high in the `done` cycle (busy=0) is accepted at that cycle's end edge. There is no dead cycle.
- Minimum spacing, accept to accept, is L+1 edges when the new `start` is issued in the `done` cycle.
- `rst` in any state, including mid-RUN:
  - the in-flight op is aborted;
  - `done` is not pulsed;
  - all outputs return to their reset values on that edge.
  - A `start` coincident with `rst` is dropped.

## Test plan
- BIN_ADD with `op_a`=1000, `op_b`=1234, cond 0, default params → `done` at E0+1, `result`=2234, `ops_served`=1.
- DEC_ADD with `op_a`=2345, `op_b`=6789:
  - cond 0 → `done` at E0+8, `result`=9134;
  - repeat with cond 3 → `done` at E0+1, same result.
- BIN_SUB with `op_a`=1234, `op_b`=3000, cond 1 → `done` at E0+6, `result`=32'hFFFFF91A.
- Sequence DUO_MUL3 (`op_a`=4095) then BIN_MUL (`op_a`=73, `op_b`=91), both cond 2, second `start` issued in the first `done` cycle:
  - first op: results 12285 at E0+1;
  - second op: 6643 at E0+1+1+6;
  - `busy` stays low only in the `done` cycle.
- DEC_MUL10 with `op_a`=1234, cond 3; pulse `start` again at E0+0.5 cycles with a different opcode:
  - the second start is ignored;
  - exactly one `done`, with `result`=12340.
- DUO_SUB12 with `op_a`=5000, `op_b`=1337, cond 0; assert `rst` at E0+3:
  - no `done`; `busy`, `result`, `ops_served` are 0 after that edge;
  - a fresh request then completes normally with 3663 at E0+6.
